// File: rtl/lsu_mem_master.sv
// LSU-side memory master: takes one load/store at a time, drives the physical memory
// model pins and returns aligned/extended load data over a valid/ready response.
module lsu_mem_master #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned ADDR_W      = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [63:0]       mem_rdata,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wmask
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_M1 = (MEM_LATENCY == 0) ? 4'd0 : 4'(MEM_LATENCY - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic              lat_we;
  logic [2:0]        lat_lane;
  logic [1:0]        lat_size;
  logic              lat_uns;

  logic              misaligned_c;
  logic              done_c;
  logic [7:0]        size_mask_c;
  logic [ADDR_W-1:0] aligned_c;
  logic [63:0]       field_c;
  logic [63:0]       load_data_c;

  // Request decode: alignment check, lane mask and 8-byte aligned address
  always_comb begin
    misaligned_c = 1'b0;
    size_mask_c  = 8'h01;
    aligned_c    = {req_addr[ADDR_W-1:3], 3'b000};
    case (req_size)
      2'd0: begin misaligned_c = 1'b0;            size_mask_c = 8'h01; end
      2'd1: begin misaligned_c = req_addr[0];     size_mask_c = 8'h03; end
      2'd2: begin misaligned_c = |req_addr[1:0];  size_mask_c = 8'h0F; end
      default: begin misaligned_c = |req_addr[2:0]; size_mask_c = 8'hFF; end
    endcase
  end

  // Memory data is sampled at the end of ACCESS (zero latency) or the last WAIT cycle
  always_comb begin
    done_c = ((state == ACCESS) && (MEM_LATENCY == 0)) ||
             ((state == WAIT) && (cnt == 4'd0));
  end

  // Load lane extraction with sign/zero extension
  always_comb begin
    field_c     = mem_rdata >> {lat_lane, 3'b000};
    load_data_c = field_c;
    case (lat_size)
      2'd0: load_data_c = lat_uns ? {56'd0, field_c[7:0]}  : {{56{field_c[7]}},  field_c[7:0]};
      2'd1: load_data_c = lat_uns ? {48'd0, field_c[15:0]} : {{48{field_c[15]}}, field_c[15:0]};
      2'd2: load_data_c = lat_uns ? {32'd0, field_c[31:0]} : {{32{field_c[31]}}, field_c[31:0]};
      default: load_data_c = field_c;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat_we     <= 1'b0;
      lat_lane   <= 3'd0;
      lat_size   <= 2'd0;
      lat_uns    <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
      mem_ren    <= 1'b0;
      mem_wen    <= 1'b0;
      mem_raddr  <= '0;
      mem_waddr  <= '0;
      mem_wdata  <= 64'd0;
      mem_wmask  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            lat_we    <= req_we;
            lat_lane  <= req_addr[2:0];
            lat_size  <= req_size;
            lat_uns   <= req_unsigned;
            req_ready <= 1'b0;
            if (misaligned_c) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 64'd0;
            end else begin
              state <= ACCESS;
              if (req_we) begin
                mem_wen   <= 1'b1;
                mem_waddr <= aligned_c;
                mem_wmask <= 8'(size_mask_c << req_addr[2:0]);
                mem_wdata <= req_wdata << {req_addr[2:0], 3'b000};
              end else begin
                mem_ren   <= 1'b1;
                mem_raddr <= aligned_c;
              end
            end
          end
        end
        ACCESS: begin
          mem_ren <= 1'b0;
          mem_wen <= 1'b0;
          if (!done_c) begin
            state <= WAIT;
            cnt   <= LAT_M1;
          end
        end
        WAIT: begin
          if (!done_c) cnt <= 4'(cnt - 4'd1);
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 64'd0;
            req_ready  <= 1'b1;
          end
        end
      endcase

      // Access complete: present the response and park the memory pins at zero
      if (done_c) begin
        state      <= RESP;
        resp_valid <= 1'b1;
        resp_err   <= 1'b0;
        resp_rdata <= lat_we ? 64'd0 : load_data_c;
        mem_raddr  <= '0;
        mem_waddr  <= '0;
        mem_wdata  <= 64'd0;
        mem_wmask  <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: one instance at MEM_LATENCY=1, one at 0.
module tb_lsu_mem_master;

  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_CAFE_F00D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_we = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b1;
  logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
  logic [1:0]  req_size = 2'd0;
  logic [63:0] mem_word = 64'd0;

  logic        req_valid = 1'b0, req_ready, resp_valid, resp_err, mem_ren, mem_wen;
  logic [63:0] resp_rdata, mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic [7:0]  mem_wmask;

  logic        req_valid0 = 1'b0, req_ready0, resp_valid0, resp_err0, mem_ren0, mem_wen0;
  logic [63:0] resp_rdata0, mem_raddr0, mem_rdata0, mem_waddr0, mem_wdata0;
  logic [7:0]  mem_wmask0;

  lsu_mem_master #(.MEM_LATENCY(1), .ADDR_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_ren(mem_ren), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask)
  );

  lsu_mem_master #(.MEM_LATENCY(0), .ADDR_W(64)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .resp_valid(resp_valid0), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0), .mem_ren(mem_ren0), .mem_raddr(mem_raddr0),
    .mem_rdata(mem_rdata0), .mem_wen(mem_wen0), .mem_waddr(mem_waddr0), .mem_wdata(mem_wdata0),
    .mem_wmask(mem_wmask0)
  );

  // Memory models: data is valid only in the cycle the latency says it should be
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_rdata <= JUNK;
    else        mem_rdata <= mem_ren ? mem_word : JUNK;
  end
  assign mem_rdata0 = mem_ren0 ? mem_word : JUNK;

  int ren_cnt = 0, wen_cnt = 0;
  always @(negedge clk) begin
    if (mem_ren) ren_cnt <= ren_cnt + 1;
    if (mem_wen) wen_cnt <= wen_cnt + 1;
  end

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int checks = 0;
  int failures = 0;

  // Drives one request for a single accepting edge; returns at the negedge after it
  task automatic send_req(input bit sel, input bit we, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [1:0] size, input bit uns);
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
    if (sel) req_valid0 = 1'b1; else req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_valid0 = 1'b0;
  endtask

  // Counts cycles since acceptance until resp_valid is seen; -1 on timeout
  task automatic wait_resp(input bit sel, output int k);
    k = 1;
    while (!(sel ? resp_valid0 : resp_valid)) begin
      if (k >= 20) begin k = -1; return; end
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 64'd0)
      begin failures++; $display("FAIL reset_resp: ready=%b valid=%b err=%b rdata=%h, required 1 0 0 0", req_ready, resp_valid, resp_err, resp_rdata); end
    checks++;
    if (mem_ren !== 1'b0 || mem_wen !== 1'b0 || mem_raddr !== 64'd0 || mem_waddr !== 64'd0 ||
        mem_wdata !== 64'd0 || mem_wmask !== 8'd0)
      begin failures++; $display("FAIL reset_mem: ren=%b wen=%b raddr=%h waddr=%h wdata=%h wmask=%h, required all 0", mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask); end
    checks++;
    if (req_ready0 !== 1'b1 || resp_valid0 !== 1'b0)
      begin failures++; $display("FAIL reset_dut0: ready=%b valid=%b, required 1 0", req_ready0, resp_valid0); end
    rst_n = 1'b1;
  endtask

  task automatic test_load_dword();
    int k, r0;
    r0 = ren_cnt;
    mem_word = 64'h1122_3344_5566_7788;
    sb.push_back('{rdata: 64'h1122_3344_5566_7788, err: 1'b0});
    send_req(0, 0, 64'h8000_0008, 64'd0, 2'd3, 0);
    checks++;
    if (mem_ren !== 1'b1 || mem_raddr !== 64'h8000_0008 || req_ready !== 1'b0)
      begin failures++; $display("FAIL ld_access: ren=%b raddr=%h ready=%b, required 1 80000008 0", mem_ren, mem_raddr, req_ready); end
    wait_resp(0, k);
    checks++;
    if (k != 3) begin failures++; $display("FAIL ld_latency: got %0d, required 3", k); end
    e = sb.pop_front();
    checks++;
    if (resp_rdata !== e.rdata || resp_err !== e.err)
      begin failures++; $display("FAIL ld_dword: rdata=%h err=%b, required %h %b", resp_rdata, resp_err, e.rdata, e.err); end
    @(negedge clk);
    checks++;
    if (ren_cnt - r0 != 1) begin failures++; $display("FAIL ld_ren_pulses: got %0d, required 1", ren_cnt - r0); end
  endtask

  task automatic test_load_byte();
    int k;
    mem_word = 64'h0000_0000_8000_0000;
    for (int u = 0; u < 2; u++) begin
      sb.push_back('{rdata: (u == 1) ? 64'h80 : 64'hFFFF_FFFF_FFFF_FF80, err: 1'b0});
      send_req(0, 0, 64'h8000_0003, 64'd0, 2'd0, u[0]);
      wait_resp(0, k);
      e = sb.pop_front();
      checks++;
      if (k != 3 || resp_rdata !== e.rdata || resp_err !== e.err)
        begin failures++; $display("FAIL ld_byte_u%0d: lat=%0d rdata=%h err=%b, required 3 %h %b", u, k, resp_rdata, resp_err, e.rdata, e.err); end
    end
    // Signed word in the upper lane
    mem_word = 64'h8765_4321_0000_0000;
    sb.push_back('{rdata: 64'hFFFF_FFFF_8765_4321, err: 1'b0});
    send_req(0, 0, 64'h8000_0014, 64'd0, 2'd2, 0);
    wait_resp(0, k);
    e = sb.pop_front();
    checks++;
    if (resp_rdata !== e.rdata || resp_err !== e.err)
      begin failures++; $display("FAIL ld_word_hi: rdata=%h err=%b, required %h %b", resp_rdata, resp_err, e.rdata, e.err); end
  endtask

  task automatic test_store_half();
    int k, w0, r0;
    w0 = wen_cnt; r0 = ren_cnt;
    sb.push_back('{rdata: 64'd0, err: 1'b0});
    send_req(0, 1, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 2'd1, 0);
    checks++;
    if (mem_wen !== 1'b1 || mem_ren !== 1'b0 || mem_waddr !== 64'h8000_0000 ||
        mem_wmask !== 8'hC0 || mem_wdata !== 64'hABCD_0000_0000_0000)
      begin failures++; $display("FAIL st_access: wen=%b ren=%b waddr=%h wmask=%h wdata=%h, required 1 0 80000000 c0 abcd000000000000", mem_wen, mem_ren, mem_waddr, mem_wmask, mem_wdata); end
    @(negedge clk);
    checks++;
    if (mem_wen !== 1'b0 || mem_waddr !== 64'h8000_0000 || mem_wmask !== 8'hC0)
      begin failures++; $display("FAIL st_wait_hold: wen=%b waddr=%h wmask=%h, required 0 80000000 c0", mem_wen, mem_waddr, mem_wmask); end
    wait_resp(0, k);
    e = sb.pop_front();
    checks++;
    if (k != 2 || resp_rdata !== e.rdata || resp_err !== e.err || mem_wen !== 1'b0 || mem_wmask !== 8'd0)
      begin failures++; $display("FAIL st_resp: lat_after_wait=%0d rdata=%h err=%b wen=%b wmask=%h, required 2 %h %b 0 00", k, resp_rdata, resp_err, mem_wen, mem_wmask, e.rdata, e.err); end
    @(negedge clk);
    checks++;
    if (wen_cnt - w0 != 1 || ren_cnt - r0 != 0)
      begin failures++; $display("FAIL st_pulses: wen=%0d ren=%0d, required 1 0", wen_cnt - w0, ren_cnt - r0); end
  endtask

  task automatic test_misaligned();
    int k, w0, r0;
    w0 = wen_cnt; r0 = ren_cnt;
    mem_word = 64'h0123_4567_89AB_CDEF;
    sb.push_back('{rdata: 64'd0, err: 1'b1});
    send_req(0, 0, 64'h8000_0002, 64'd0, 2'd2, 0);
    wait_resp(0, k);
    e = sb.pop_front();
    checks++;
    if (k != 1 || resp_rdata !== e.rdata || resp_err !== e.err)
      begin failures++; $display("FAIL misaligned: lat=%0d rdata=%h err=%b, required 1 %h %b", k, resp_rdata, resp_err, e.rdata, e.err); end
    @(negedge clk);
    checks++;
    if (wen_cnt - w0 != 0 || ren_cnt - r0 != 0)
      begin failures++; $display("FAIL misaligned_enables: wen=%0d ren=%0d, required 0 0", wen_cnt - w0, ren_cnt - r0); end
  endtask

  task automatic test_back_to_back();
    int k;
    logic [63:0] held;
    resp_ready = 1'b0;
    mem_word = 64'h8765_4321_0000_0000;
    sb.push_back('{rdata: 64'hFFFF_FFFF_8765_4321, err: 1'b0});
    send_req(0, 0, 64'h8000_0014, 64'd0, 2'd2, 0);
    wait_resp(0, k);
    e = sb.pop_front();
    held = resp_rdata;
    checks++;
    if (k != 3 || resp_rdata !== e.rdata)
      begin failures++; $display("FAIL bp_first: lat=%0d rdata=%h, required 3 %h", k, resp_rdata, e.rdata); end
    req_we = 1'b1; req_addr = 64'h8000_0001; req_wdata = 64'h5A; req_size = 2'd0; req_unsigned = 1'b0;
    req_valid = 1'b1;
    sb.push_back('{rdata: 64'd0, err: 1'b0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== held || req_ready !== 1'b0 || mem_wen !== 1'b0)
        begin failures++; $display("FAIL bp_hold%0d: valid=%b rdata=%h ready=%b wen=%b, required 1 %h 0 0", i, resp_valid, resp_rdata, held, req_ready, mem_wen); end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_wen !== 1'b0)
      begin failures++; $display("FAIL bp_release: valid=%b ready=%b wen=%b, required 0 1 0", resp_valid, req_ready, mem_wen); end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (mem_wen !== 1'b1 || mem_wmask !== 8'h02 || mem_wdata !== 64'h5A00 || req_ready !== 1'b0)
      begin failures++; $display("FAIL bp_second_access: wen=%b wmask=%h wdata=%h ready=%b, required 1 02 5a00 0", mem_wen, mem_wmask, mem_wdata, req_ready); end
    wait_resp(0, k);
    e = sb.pop_front();
    checks++;
    if (k != 3 || resp_rdata !== e.rdata || resp_err !== e.err)
      begin failures++; $display("FAIL bp_second_resp: lat=%0d rdata=%h err=%b, required 3 %h %b", k, resp_rdata, resp_err, e.rdata, e.err); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    mem_word = 64'h1122_3344_5566_7788;
    send_req(0, 0, 64'h8000_0008, 64'd0, 2'd3, 0);
    @(negedge clk);
    checks++;
    if (mem_ren !== 1'b0 || mem_raddr !== 64'h8000_0008 || resp_valid !== 1'b0)
      begin failures++; $display("FAIL wait_state: ren=%b raddr=%h valid=%b, required 0 80000008 0", mem_ren, mem_raddr, resp_valid); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_ren !== 1'b0 || mem_raddr !== 64'd0 || resp_rdata !== 64'd0)
      begin failures++; $display("FAIL async_reset: ready=%b valid=%b ren=%b raddr=%h rdata=%h, required 1 0 0 0 0", req_ready, resp_valid, mem_ren, mem_raddr, resp_rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1 || mem_ren === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL post_reset_quiet: activity=%b, required 0", seen); end
  endtask

  task automatic test_latency0();
    int k;
    mem_word = 64'h1122_3344_5566_7788;
    sb.push_back('{rdata: 64'h1122_3344_5566_7788, err: 1'b0});
    send_req(1, 0, 64'h8000_0008, 64'd0, 2'd3, 0);
    checks++;
    if (mem_ren0 !== 1'b1 || mem_raddr0 !== 64'h8000_0008)
      begin failures++; $display("FAIL l0_access: ren=%b raddr=%h, required 1 80000008", mem_ren0, mem_raddr0); end
    wait_resp(1, k);
    e = sb.pop_front();
    checks++;
    if (k != 2 || resp_rdata0 !== e.rdata || resp_err0 !== e.err || mem_ren0 !== 1'b0)
      begin failures++; $display("FAIL l0_resp: lat=%0d rdata=%h err=%b ren=%b, required 2 %h %b 0", k, resp_rdata0, resp_err0, mem_ren0, e.rdata, e.err); end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_dword();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    test_latency0();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover: %0d entries, required 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
